// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronizes pll_locked, sequences downstream reset release and video enable.
// Optional watchdog (pll_rst pulse on lock timeout) is compiled only when LOCK_WATCHDOG_EN is defined.
module pll_lock_supervisor #(
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       clear_status,
  output logic       sys_reset_n,
  output logic       video_en,
  output logic       lock_lost,
  output logic [7:0] loss_count,
  output logic [1:0] state,
  output logic       pll_rst,
  output logic       wd_timeout
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int unsigned STAB_W = 16;
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  // Elaboration-time guard on the parameter ranges.
  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535 || HOLD_CYCLES < 1 || HOLD_CYCLES > 255 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("pll_lock_supervisor: parameter out of range");
  end

  state_e              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                locked_s_q, locked_s_d;
  logic [STAB_W-1:0]   stab_cnt_q, stab_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                sys_reset_n_q, sys_reset_n_d;
  logic                video_en_q, video_en_d;
  logic                lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0]    loss_count_q, loss_count_d;
  logic                loss_c;

`ifdef LOCK_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [HOLD_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic              pll_rst_q, pll_rst_d;
  logic              wd_timeout_q, wd_timeout_d;
`endif

  // Next-state, counters and status.
  always_comb begin
    state_d      = state_q;
    sync1_d      = pll_locked;
    locked_s_d   = sync1_q;
    stab_cnt_d   = '0;
    hold_cnt_d   = '0;
    lock_lost_d  = lock_lost_q;
    loss_count_d = loss_count_q;
    loss_c       = 1'b0;
`ifdef LOCK_WATCHDOG_EN
    wd_cnt_d     = wd_cnt_q;
    pulse_cnt_d  = '0;
    pll_rst_d    = pll_rst_q;
    wd_timeout_d = wd_timeout_q;
`endif

    case (state_q)
      WAIT_LOCK: begin
        if (locked_s_q) state_d = STABILIZE;
      end
      STABILIZE: begin
        if (!locked_s_q)                state_d = WAIT_LOCK;
        else if (stab_cnt_q == STAB_LAST) state_d = HOLD;
        else                             stab_cnt_d = stab_cnt_q + 1'b1;
      end
      HOLD: begin
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          loss_c  = 1'b1;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          loss_c  = 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

`ifdef LOCK_WATCHDOG_EN
    // While the pll_rst pulse is active the FSM is pinned in WAIT_LOCK.
    if (pll_rst_q) begin
      state_d    = WAIT_LOCK;
      stab_cnt_d = '0;
      hold_cnt_d = '0;
      wd_cnt_d   = '0;
      if (pulse_cnt_q == HOLD_LAST) pll_rst_d = 1'b0;
      else                          pulse_cnt_d = pulse_cnt_q + 1'b1;
    end else if (state_q == WAIT_LOCK || state_q == STABILIZE) begin
      if (wd_cnt_q == WD_LAST) begin
        pll_rst_d  = 1'b1;
        wd_cnt_d   = '0;
        state_d    = WAIT_LOCK;
        stab_cnt_d = '0;
      end else if (state_d == HOLD) begin
        wd_cnt_d = '0;
      end else begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
    end else begin
      wd_cnt_d = '0;
    end
`endif

    // A loss on the same edge as clear_status takes priority.
    if (clear_status) begin
      lock_lost_d  = 1'b0;
      loss_count_d = '0;
`ifdef LOCK_WATCHDOG_EN
      wd_timeout_d = 1'b0;
`endif
    end
    if (loss_c) begin
      lock_lost_d = 1'b1;
      if (loss_count_d != '1) loss_count_d = loss_count_d + 1'b1;
    end
`ifdef LOCK_WATCHDOG_EN
    if (pll_rst_d && !pll_rst_q) wd_timeout_d = 1'b1;
`endif

    sys_reset_n_d = (state_d == HOLD) || (state_d == RUN);
    video_en_d    = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= WAIT_LOCK;
      sync1_q       <= 1'b0;
      locked_s_q    <= 1'b0;
      stab_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      sys_reset_n_q <= 1'b0;
      video_en_q    <= 1'b0;
      lock_lost_q   <= 1'b0;
      loss_count_q  <= '0;
`ifdef LOCK_WATCHDOG_EN
      wd_cnt_q      <= '0;
      pulse_cnt_q   <= '0;
      pll_rst_q     <= 1'b0;
      wd_timeout_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      locked_s_q    <= locked_s_d;
      stab_cnt_q    <= stab_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      sys_reset_n_q <= sys_reset_n_d;
      video_en_q    <= video_en_d;
      lock_lost_q   <= lock_lost_d;
      loss_count_q  <= loss_count_d;
`ifdef LOCK_WATCHDOG_EN
      wd_cnt_q      <= wd_cnt_d;
      pulse_cnt_q   <= pulse_cnt_d;
      pll_rst_q     <= pll_rst_d;
      wd_timeout_q  <= wd_timeout_d;
`endif
    end
  end

  assign state       = state_q;
  assign sys_reset_n = sys_reset_n_q;
  assign video_en    = video_en_q;
  assign lock_lost   = lock_lost_q;
  assign loss_count  = loss_count_q;
`ifdef LOCK_WATCHDOG_EN
  assign pll_rst     = pll_rst_q;
  assign wd_timeout  = wd_timeout_q;
`else
  assign pll_rst     = 1'b0;
  assign wd_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: cycle-accurate vector table plus saturation, clear, watchdog and reset sequences.
module tb_pll_lock_supervisor;

  localparam int unsigned STABLE  = 8;
  localparam int unsigned HOLD    = 4;
  localparam int unsigned TIMEOUT = 50;

  logic       clk = 1'b0;
  logic       reset_n, pll_locked, clear_status;
  logic       sys_reset_n, video_en, lock_lost, pll_rst, wd_timeout;
  logic [7:0] loss_count;
  logic [1:0] state;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .STABLE_CYCLES (STABLE),
    .HOLD_CYCLES   (HOLD),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .clear_status(clear_status),
    .sys_reset_n (sys_reset_n),
    .video_en    (video_en),
    .lock_lost   (lock_lost),
    .loss_count  (loss_count),
    .state       (state),
    .pll_rst     (pll_rst),
    .wd_timeout  (wd_timeout)
  );

  typedef struct {
    logic       rst_n;
    logic       lck;
    logic       clr;
    logic [1:0] st;
    logic       srn;
    logic       ven;
    logic       lost;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Append n identical cycles: inputs for the edge, then the outputs expected after it.
  task automatic add(input int n, input logic r, input logic l, input logic c, input logic [1:0] st,
                     input logic srn, input logic ven, input logic lost, input logic [7:0] cnt);
    vec_t v;
    v.rst_n = r; v.lck = l; v.clr = c; v.st = st;
    v.srn = srn; v.ven = ven; v.lost = lost; v.cnt = cnt;
    repeat (n) tbl.push_back(v);
  endtask

  task automatic cyc(input logic r, input logic l, input logic c);
    reset_n = r; pll_locked = l; clear_status = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; pll_locked = 1'b0; clear_status = 1'b0;

    // Reset, then clean lock (edge 0 = first sample of pll_locked high) and loss in RUN at edge 20.
    add(2, 0,0,0, 2'd0, 0,0,0, 8'd0);
    add(2, 1,1,0, 2'd0, 0,0,0, 8'd0);   // edges 0-1
    add(8, 1,1,0, 2'd1, 0,0,0, 8'd0);   // 2-9 STABILIZE
    add(4, 1,1,0, 2'd2, 1,0,0, 8'd0);   // 10-13 HOLD
    add(6, 1,1,0, 2'd3, 1,1,0, 8'd0);   // 14-19 RUN
    add(2, 1,0,0, 2'd3, 1,1,0, 8'd0);   // 20-21 drop propagating
    add(1, 1,0,0, 2'd0, 0,0,1, 8'd1);   // 22 loss counted
    add(1, 1,0,1, 2'd0, 0,0,0, 8'd0);   // clear alone
    // Relock from WAIT_LOCK, then reset mid-RUN and relock with the same timing.
    add(2, 1,1,0, 2'd0, 0,0,0, 8'd0);
    add(8, 1,1,0, 2'd1, 0,0,0, 8'd0);
    add(4, 1,1,0, 2'd2, 1,0,0, 8'd0);
    add(2, 1,1,0, 2'd3, 1,1,0, 8'd0);
    add(1, 0,1,0, 2'd0, 0,0,0, 8'd0);
    add(2, 1,1,0, 2'd0, 0,0,0, 8'd0);
    add(8, 1,1,0, 2'd1, 0,0,0, 8'd0);
    add(4, 1,1,0, 2'd2, 1,0,0, 8'd0);
    add(1, 1,1,0, 2'd3, 1,1,0, 8'd0);
    // Glitch in STABILIZE at edge 6: back to WAIT_LOCK at 8, full restart, not counted.
    add(1, 0,0,0, 2'd0, 0,0,0, 8'd0);
    add(2, 1,1,0, 2'd0, 0,0,0, 8'd0);   // 0-1
    add(4, 1,1,0, 2'd1, 0,0,0, 8'd0);   // 2-5
    add(1, 1,0,0, 2'd1, 0,0,0, 8'd0);   // 6
    add(1, 1,1,0, 2'd1, 0,0,0, 8'd0);   // 7
    add(1, 1,1,0, 2'd0, 0,0,0, 8'd0);   // 8
    add(8, 1,1,0, 2'd1, 0,0,0, 8'd0);   // 9-16
    add(4, 1,1,0, 2'd2, 1,0,0, 8'd0);   // 17-20
    add(1, 1,1,0, 2'd3, 1,1,0, 8'd0);   // 21

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t e;
      reset_n      = tbl[i].rst_n;
      pll_locked   = tbl[i].lck;
      clear_status = tbl[i].clr;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("row%0d.state", i),       8'(state),       8'(e.st));
      chk($sformatf("row%0d.sys_reset_n", i), 8'(sys_reset_n), 8'(e.srn));
      chk($sformatf("row%0d.video_en", i),    8'(video_en),    8'(e.ven));
      chk($sformatf("row%0d.lock_lost", i),   8'(lock_lost),   8'(e.lost));
      chk($sformatf("row%0d.loss_count", i),  loss_count,      e.cnt);
      chk($sformatf("row%0d.pll_rst", i),     8'(pll_rst),     8'd0);
      chk($sformatf("row%0d.wd_timeout", i),  8'(wd_timeout),  8'd0);
    end

    // 300 loss/relock cycles through HOLD: count saturates at 255.
    cyc(0, 0, 0);
    for (int it = 1; it <= 300; it++) begin
      repeat (11) cyc(1, 1, 0);
      repeat (3) cyc(1, 0, 0);
      if (it == 1)   chk("sat_first", loss_count, 8'd1);
      if (it == 254) chk("sat_254", loss_count, 8'd254);
      if (it == 255 || it == 300) chk($sformatf("sat_%0d", it), loss_count, 8'd255);
    end
    chk("sat_lost", 8'(lock_lost), 8'd1);
    chk("sat_state", 8'(state), 8'd0);

    // clear_status on the same edge as a loss: loss wins with a fresh count of 1.
    repeat (11) cyc(1, 1, 0);
    repeat (2) cyc(1, 0, 0);
    cyc(1, 0, 1);
    chk("clr_loss_lost", 8'(lock_lost), 8'd1);
    chk("clr_loss_count", loss_count, 8'd1);
    cyc(1, 0, 1);
    chk("clr_only_lost", 8'(lock_lost), 8'd0);
    chk("clr_only_count", loss_count, 8'd0);

    // Watchdog behaviour with pll_locked held low; edge 0 is the reset edge.
    cyc(0, 0, 0);
`ifdef LOCK_WATCHDOG_EN
    for (int k = 1; k <= 120; k++) begin
      logic exp_rst;
      cyc(1, 0, 0);
      exp_rst = (k >= 50) && (((k - 50) % 54) < 4);
      chk($sformatf("wd_pll_rst_e%0d", k), 8'(pll_rst), 8'(exp_rst));
      chk($sformatf("wd_timeout_e%0d", k), 8'(wd_timeout), 8'(k >= 50));
    end
    chk("wd_state", 8'(state), 8'd0);
    cyc(0, 0, 0);
    repeat (51) cyc(1, 0, 0);
    chk("wd_pulse_mid", 8'(pll_rst), 8'd1);
    cyc(0, 0, 0);
    chk("wd_rst_pulse_cut", 8'(pll_rst), 8'd0);
    chk("wd_rst_timeout", 8'(wd_timeout), 8'd0);
    cyc(1, 0, 0);
    chk("wd_after_rst", 8'(pll_rst), 8'd0);
`else
    for (int k = 1; k <= 120; k++) begin
      cyc(1, 0, 0);
      chk($sformatf("nowd_pll_rst_e%0d", k), 8'(pll_rst), 8'd0);
    end
    chk("nowd_state", 8'(state), 8'd0);
    chk("nowd_timeout", 8'(wd_timeout), 8'd0);
    chk("nowd_sys_reset_n", 8'(sys_reset_n), 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
